map9v3_sched: RTL

//  Round-robin scheduler sharing one map9v3 N->LFSR-reset mapper among NREQ requesters.

---
 rtl/map9v3_sched.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/map9v3_sched.sv
// map9v3_sched: round-robin scheduler sharing one map9v3 mapper among NREQ requesters.
// Latches the granted requester's N onto map_n, pulses map_start, waits for the mapper
// to clear and then re-raise map_done, and returns map_dp with a one-cycle one-hot ack.
//
// Ports:
//   clock, reset_n     rising-edge clock, asynchronous active-low reset
//   req[NREQ]          level requests, held until ack
//   n_in[9*NREQ]       requester i's N at n_in[9*i+8:9*i]
//   ack[NREQ]          one-hot pulse, result_dp valid for that requester
//   result_dp[9]       mapped value, held until the next ack
//   err                pulse with ack when a run was aborted by the watchdog
//   busy               high in every state except IDLE
//   map_start, map_n   mapper start pulse and N (N stable from ISSUE until done seen)
//   map_dp, map_done   mapper result and level done flag
//
// Configuration macro: ERR_TIMEOUT_EN adds a 9-bit watchdog over START_LO+RUN; when it
// reaches TIMEOUT the run is acked with err=1 and result_dp=0, then the block resyncs
// through BOOT. Without the macro the block waits indefinitely and err is tied low.
module map9v3_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 511
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [9*NREQ-1:0] n_in,
  output logic [NREQ-1:0]   ack,
  output logic [8:0]        result_dp,
  output logic              err,
  output logic              busy,
  output logic              map_start,
  output logic [8:0]        map_n,
  input  logic [8:0]        map_dp,
  input  logic              map_done
);

  localparam int unsigned NW = 9;
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Elaboration-time parameter sanity checks
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("map9v3_sched: NREQ must be in 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 511) begin : g_bad_timeout
    $error("map9v3_sched: TIMEOUT must be in 1..511");
  end

  typedef enum logic [2:0] {
    BOOT     = 3'd0,
    IDLE     = 3'd1,
    ISSUE    = 3'd2,
    START_LO = 3'd3,
    RUN      = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   gnt, gnt_nxt;
  logic [PW-1:0]   rr_ptr, rr_nxt;
  logic [NREQ-1:0] ack_nxt;
  logic [NW-1:0]   result_nxt;
  logic            start_nxt;
  logic [NW-1:0]   map_n_nxt;
  logic            busy_nxt;

  logic [NREQ-1:0] req_m;
  logic            pick_vld;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   cand;
  logic [NW-1:0]   n_arr [NREQ];

`ifdef ERR_TIMEOUT_EN
  localparam logic [8:0] WD_LAST = 9'(TIMEOUT - 1);
  logic [8:0] wdog, wdog_nxt;
  logic       err_nxt;
`endif

  // Unpack the flat N bus into one 9-bit lane per requester
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign n_arr[i] = n_in[NW*i +: NW];
  end

  // During the ack cycle the acked requester's req is stale (client drops it on ack)
  assign req_m = req & ~ack;

  // Round-robin pick: scan from farthest to nearest after rr_ptr so nearest wins
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned i = NREQ; i >= 1; i--) begin
      cand = PW'((32'(rr_ptr) + i) % NREQ);
      if (req_m[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= BOOT;
      gnt       <= '0;
      rr_ptr    <= PW'(NREQ - 1);
      ack       <= '0;
      result_dp <= '0;
      map_start <= 1'b0;
      map_n     <= '0;
      busy      <= 1'b1;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      rr_ptr    <= rr_nxt;
      ack       <= ack_nxt;
      result_dp <= result_nxt;
      map_start <= start_nxt;
      map_n     <= map_n_nxt;
      busy      <= busy_nxt;
    end
  end

`ifdef ERR_TIMEOUT_EN
  // Watchdog counter and error pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wdog <= '0;
      err  <= 1'b0;
    end else begin
      wdog <= wdog_nxt;
      err  <= err_nxt;
    end
  end
`else
  assign err = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    rr_nxt     = rr_ptr;
    ack_nxt    = '0;
    result_nxt = result_dp;
    start_nxt  = 1'b0;
    map_n_nxt  = map_n;
`ifdef ERR_TIMEOUT_EN
    err_nxt    = 1'b0;
    wdog_nxt   = '0;
`endif

    case (state)
      // Mapper self-runs out of reset; its first result is discarded
      BOOT: begin
        if (map_done) state_nxt = IDLE;
      end
      // Grant, latch N, and raise map_start so it is high exactly while in ISSUE
      IDLE: begin
        if (pick_vld) begin
          gnt_nxt   = pick_idx;
          map_n_nxt = n_arr[pick_idx];
          start_nxt = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = START_LO;
      end
      // A stale done from the previous run must clear before a fresh one counts
      START_LO: begin
        if (!map_done) state_nxt = RUN;
      end
      RUN: begin
        if (map_done) begin
          result_nxt = map_dp;
          ack_nxt    = NREQ'(1) << gnt;
          rr_nxt     = gnt;
          state_nxt  = IDLE;
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase

`ifdef ERR_TIMEOUT_EN
    // Abort a run that has spent TIMEOUT cycles in START_LO+RUN without completing
    if (state == START_LO || state == RUN) begin
      wdog_nxt = wdog + 9'd1;
      if (wdog == WD_LAST && !(state == RUN && map_done)) begin
        ack_nxt    = NREQ'(1) << gnt;
        err_nxt    = 1'b1;
        result_nxt = '0;
        rr_nxt     = gnt;
        wdog_nxt   = '0;
        state_nxt  = BOOT;
      end
    end
`endif

    busy_nxt = (state_nxt != IDLE);
  end

endmodule
